// File: rtl/ld_st_issue_queue.sv
// In-order load/store issue queue: holds dispatched LD/ST entries, snoops the CDB for
// pending operands and issues the head once ready. Optional: LDST_CDB_BYPASS_EN.
module ld_st_issue_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TAG_W  = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dispatch_en,
  input  logic              d_ld_st_opcode,
  input  logic [TAG_W-1:0]  d_rs1_tag,
  input  logic [DATA_W-1:0] d_rs1_data,
  input  logic              d_rs1_valid,
  input  logic [TAG_W-1:0]  d_rs2_tag,
  input  logic [DATA_W-1:0] d_rs2_data,
  input  logic              d_rs2_valid,
  input  logic [DATA_W-1:0] d_immediate,
  input  logic [TAG_W-1:0]  d_rd_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_result,
  input  logic              mem_stall,
  output logic              queue_full,
  output logic              issue_queue_rdy,
  output logic              i_ld_st_opcode,
  output logic [DATA_W-1:0] i_rs1_data,
  output logic [DATA_W-1:0] i_rs2_data,
  output logic [DATA_W-1:0] i_immediate,
  output logic [TAG_W-1:0]  i_rd_tag
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PtrOne  = 1;
  localparam logic [PTR_W:0]   CntOne  = 1;
  localparam logic [PTR_W:0]   FullCnt = DEPTH[PTR_W:0];

  logic [DEPTH-1:0]  vld_q, op_q, rs1_v_q, rs2_v_q;
  logic [TAG_W-1:0]  rs1_tag_q  [DEPTH];
  logic [TAG_W-1:0]  rs2_tag_q  [DEPTH];
  logic [TAG_W-1:0]  rd_tag_q   [DEPTH];
  logic [DATA_W-1:0] rs1_data_q [DEPTH];
  logic [DATA_W-1:0] rs2_data_q [DEPTH];
  logic [DATA_W-1:0] imm_q      [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;

  logic              head_ready, push, pop;
  logic              new_rs1_valid, new_rs2_valid;
  logic [DATA_W-1:0] new_rs1_data, new_rs2_data;

  assign queue_full      = (count == FullCnt);
  assign head_ready      = vld_q[rd_ptr] && rs1_v_q[rd_ptr] && (!op_q[rd_ptr] || rs2_v_q[rd_ptr]);
  assign issue_queue_rdy = head_ready && !mem_stall;
  assign pop             = issue_queue_rdy;
  assign push            = dispatch_en && (!queue_full || pop);

  always_comb begin
    new_rs1_valid = d_rs1_valid;
    new_rs1_data  = d_rs1_data;
    new_rs2_valid = d_rs2_valid;
    new_rs2_data  = d_rs2_data;
`ifdef LDST_CDB_BYPASS_EN
    // Catch a broadcast that coincides with dispatch of its consumer.
    if (cdb_valid && !d_rs1_valid && d_rs1_tag == cdb_tag) begin
      new_rs1_valid = 1'b1;
      new_rs1_data  = cdb_result;
    end
    if (cdb_valid && !d_rs2_valid && d_rs2_tag == cdb_tag) begin
      new_rs2_valid = 1'b1;
      new_rs2_data  = cdb_result;
    end
`endif
  end

  always_comb begin
    i_ld_st_opcode = 1'b0;
    i_rs1_data     = '0;
    i_rs2_data     = '0;
    i_immediate    = '0;
    i_rd_tag       = '0;
    if (vld_q[rd_ptr]) begin
      i_ld_st_opcode = op_q[rd_ptr];
      i_rs1_data     = rs1_data_q[rd_ptr];
      i_rs2_data     = rs2_data_q[rd_ptr];
      i_immediate    = imm_q[rd_ptr];
      i_rd_tag       = rd_tag_q[rd_ptr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      vld_q   <= '0;
      op_q    <= '0;
      rs1_v_q <= '0;
      rs2_v_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rs1_tag_q[i]  <= '0;
        rs2_tag_q[i]  <= '0;
        rd_tag_q[i]   <= '0;
        rs1_data_q[i] <= '0;
        rs2_data_q[i] <= '0;
        imm_q[i]      <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (vld_q[i] && cdb_valid) begin
          if (!rs1_v_q[i] && rs1_tag_q[i] == cdb_tag) begin
            rs1_data_q[i] <= cdb_result;
            rs1_v_q[i]    <= 1'b1;
          end
          if (!rs2_v_q[i] && rs2_tag_q[i] == cdb_tag) begin
            rs2_data_q[i] <= cdb_result;
            rs2_v_q[i]    <= 1'b1;
          end
        end
      end
      if (pop) begin
        vld_q[rd_ptr]   <= 1'b0;
        rs1_v_q[rd_ptr] <= 1'b0;
        rs2_v_q[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + PtrOne;
      end
      // Placed after the pop so a full-queue push into the slot being freed wins.
      if (push) begin
        vld_q[wr_ptr]      <= 1'b1;
        op_q[wr_ptr]       <= d_ld_st_opcode;
        rs1_tag_q[wr_ptr]  <= d_rs1_tag;
        rs1_data_q[wr_ptr] <= new_rs1_data;
        rs1_v_q[wr_ptr]    <= new_rs1_valid;
        rs2_tag_q[wr_ptr]  <= d_rs2_tag;
        rs2_data_q[wr_ptr] <= new_rs2_data;
        rs2_v_q[wr_ptr]    <= new_rs2_valid;
        imm_q[wr_ptr]      <= d_immediate;
        rd_tag_q[wr_ptr]   <= d_rd_tag;
        wr_ptr             <= wr_ptr + PtrOne;
      end
      if (push && !pop) begin
        count <= count + CntOne;
      end else if (pop && !push) begin
        count <= count - CntOne;
      end
    end
  end

endmodule

// File: tb/tb_ld_st_issue_queue.sv
// Bench for ld_st_issue_queue: directed scenarios plus randomized traffic checked
// against a queue-based program-order model.
module tb_ld_st_issue_queue;

  localparam int DEPTH  = 4;
  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              dispatch_en, d_ld_st_opcode, d_rs1_valid, d_rs2_valid;
  logic [TAG_W-1:0]  d_rs1_tag, d_rs2_tag, d_rd_tag, cdb_tag;
  logic [DATA_W-1:0] d_rs1_data, d_rs2_data, d_immediate, cdb_result;
  logic              cdb_valid, mem_stall;
  logic              queue_full, issue_queue_rdy, i_ld_st_opcode;
  logic [DATA_W-1:0] i_rs1_data, i_rs2_data, i_immediate;
  logic [TAG_W-1:0]  i_rd_tag;

  int passed = 0;
  int total  = 0;

  ld_st_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .dispatch_en(dispatch_en), .d_ld_st_opcode(d_ld_st_opcode),
    .d_rs1_tag(d_rs1_tag), .d_rs1_data(d_rs1_data), .d_rs1_valid(d_rs1_valid),
    .d_rs2_tag(d_rs2_tag), .d_rs2_data(d_rs2_data), .d_rs2_valid(d_rs2_valid),
    .d_immediate(d_immediate), .d_rd_tag(d_rd_tag), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_result(cdb_result), .mem_stall(mem_stall),
    .queue_full(queue_full), .issue_queue_rdy(issue_queue_rdy),
    .i_ld_st_opcode(i_ld_st_opcode), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
    .i_immediate(i_immediate), .i_rd_tag(i_rd_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              op;
    logic [TAG_W-1:0]  t1, t2, rd;
    logic [DATA_W-1:0] d1, d2, imm;
    logic              v1, v2;
  } ent_t;

  ent_t mq[$];

  function automatic logic model_rdy();
    if (mq.size() == 0) return 1'b0;
    return mq[0].v1 && (mq[0].op == 1'b0 || mq[0].v2) && !mem_stall;
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_update();
    logic pop, push;
    ent_t e;
    if (rst) begin
      mq.delete();
      return;
    end
    pop  = model_rdy();
    push = dispatch_en && (mq.size() < DEPTH || pop);
    foreach (mq[i]) begin
      if (cdb_valid && !mq[i].v1 && mq[i].t1 == cdb_tag) begin
        mq[i].v1 = 1'b1; mq[i].d1 = cdb_result;
      end
      if (cdb_valid && !mq[i].v2 && mq[i].t2 == cdb_tag) begin
        mq[i].v2 = 1'b1; mq[i].d2 = cdb_result;
      end
    end
    if (pop) void'(mq.pop_front());
    if (push) begin
      e.op = d_ld_st_opcode; e.t1 = d_rs1_tag; e.d1 = d_rs1_data; e.v1 = d_rs1_valid;
      e.t2 = d_rs2_tag; e.d2 = d_rs2_data; e.v2 = d_rs2_valid; e.imm = d_immediate;
      e.rd = d_rd_tag;
`ifdef LDST_CDB_BYPASS_EN
      if (cdb_valid && !e.v1 && e.t1 == cdb_tag) begin e.v1 = 1'b1; e.d1 = cdb_result; end
      if (cdb_valid && !e.v2 && e.t2 == cdb_tag) begin e.v2 = 1'b1; e.d2 = cdb_result; end
`endif
      mq.push_back(e);
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    dispatch_en = 0; d_ld_st_opcode = 0; d_rs1_tag = 0; d_rs1_data = 0; d_rs1_valid = 0;
    d_rs2_tag = 0; d_rs2_data = 0; d_rs2_valid = 0; d_immediate = 0; d_rd_tag = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_result = 0; mem_stall = 0;
  endtask

  task automatic disp(input logic op, input logic [TAG_W-1:0] t1, input logic [DATA_W-1:0] d1,
                      input logic v1, input logic [TAG_W-1:0] t2, input logic [DATA_W-1:0] d2,
                      input logic v2, input logic [DATA_W-1:0] imm, input logic [TAG_W-1:0] rd);
    dispatch_en = 1; d_ld_st_opcode = op; d_rs1_tag = t1; d_rs1_data = d1; d_rs1_valid = v1;
    d_rs2_tag = t2; d_rs2_data = d2; d_rs2_valid = v2; d_immediate = imm; d_rd_tag = rd;
  endtask

  task automatic test_reset();
    for (int k = 0; k < DEPTH; k++) begin
      disp(1'b0, 6'd60, 32'h0, 1'b0, 6'd0, 32'h0, 1'b0, 32'h4, 6'(40 + k));
      tick();
    end
    clear_inputs();
    settle();
    total++;
    if (queue_full !== 1'b1) $display("FAIL reset_prefill_full got %b want 1", queue_full);
    else passed++;
    rst = 1;
    #1;
    total++;
    if ({queue_full, issue_queue_rdy, i_ld_st_opcode} !== 3'b000 || i_rs1_data !== '0 ||
        i_rs2_data !== '0 || i_immediate !== '0 || i_rd_tag !== '0)
      $display("FAIL reset_outputs got full=%b rdy=%b rd=%0d want all zero",
               queue_full, issue_queue_rdy, i_rd_tag);
    else passed++;
    tick();
    rst = 0;
    settle();
    total++;
    if (queue_full !== 1'b0 || issue_queue_rdy !== 1'b0 || i_rd_tag !== '0)
      $display("FAIL reset_released got full=%b rdy=%b rd=%0d want 0 0 0",
               queue_full, issue_queue_rdy, i_rd_tag);
    else passed++;
    tick();
  endtask

  task automatic test_ready_load();
    disp(1'b0, 6'd1, 32'h100, 1'b1, 6'd0, 32'h0, 1'b0, 32'h8, 6'd5);
    tick();
    clear_inputs();
    settle();
    total++;
    if (issue_queue_rdy !== 1'b1 || i_rs1_data !== 32'h100 || i_rd_tag !== 6'd5 ||
        i_immediate !== 32'h8 || i_ld_st_opcode !== 1'b0)
      $display("FAIL ready_load got rdy=%b rs1=%h rd=%0d imm=%h want 1 100 5 8",
               issue_queue_rdy, i_rs1_data, i_rd_tag, i_immediate);
    else passed++;
    tick();
    settle();
    total++;
    if (issue_queue_rdy !== 1'b0 || i_rd_tag !== '0)
      $display("FAIL ready_load_empty got rdy=%b rd=%0d want 0 0", issue_queue_rdy, i_rd_tag);
    else passed++;
    tick();
  endtask

  task automatic test_wakeup();
    disp(1'b1, 6'd2, 32'h40, 1'b1, 6'd9, 32'h0, 1'b0, 32'h0, 6'd12);
    tick();
    clear_inputs();
    settle();
    total++;
    if (issue_queue_rdy !== 1'b0)
      $display("FAIL wakeup_wait got rdy=%b want 0", issue_queue_rdy);
    else passed++;
    cdb_valid = 1; cdb_tag = 6'd9; cdb_result = 32'hCAFE;
    #1;
    total++;
    if (issue_queue_rdy !== 1'b0)
      $display("FAIL wakeup_same_cycle got rdy=%b want 0", issue_queue_rdy);
    else passed++;
    tick();
    clear_inputs();
    settle();
    total++;
    if (issue_queue_rdy !== 1'b1 || i_rs2_data !== 32'hCAFE || i_ld_st_opcode !== 1'b1)
      $display("FAIL wakeup_ready got rdy=%b rs2=%h op=%b want 1 cafe 1",
               issue_queue_rdy, i_rs2_data, i_ld_st_opcode);
    else passed++;
    tick();
  endtask

  task automatic test_ordering();
    disp(1'b1, 6'd3, 32'h0, 1'b0, 6'd4, 32'h55, 1'b1, 32'h0, 6'd10);
    tick();
    disp(1'b0, 6'd8, 32'h300, 1'b1, 6'd0, 32'h0, 1'b0, 32'h0, 6'd11);
    tick();
    clear_inputs();
    tick();
    settle();
    total++;
    if (issue_queue_rdy !== 1'b0 || i_rd_tag !== 6'd10)
      $display("FAIL order_blocked got rdy=%b rd=%0d want 0 10", issue_queue_rdy, i_rd_tag);
    else passed++;
    cdb_valid = 1; cdb_tag = 6'd3; cdb_result = 32'h200;
    tick();
    clear_inputs();
    settle();
    total++;
    if (issue_queue_rdy !== 1'b1 || i_rd_tag !== 6'd10 || i_rs1_data !== 32'h200)
      $display("FAIL order_head got rdy=%b rd=%0d rs1=%h want 1 10 200",
               issue_queue_rdy, i_rd_tag, i_rs1_data);
    else passed++;
    tick();
    settle();
    total++;
    if (issue_queue_rdy !== 1'b1 || i_rd_tag !== 6'd11)
      $display("FAIL order_younger got rdy=%b rd=%0d want 1 11", issue_queue_rdy, i_rd_tag);
    else passed++;
    tick();
  endtask

  task automatic test_full_wrap();
    mem_stall = 1;
    for (int k = 0; k < DEPTH; k++) begin
      disp(1'b0, 6'd0, 32'(k), 1'b1, 6'd0, 32'h0, 1'b0, 32'h0, 6'(20 + k));
      tick();
    end
    disp(1'b0, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0, 1'b0, 32'h0, 6'd30);
    settle();
    total++;
    if (queue_full !== 1'b1 || issue_queue_rdy !== 1'b0)
      $display("FAIL full_set got full=%b rdy=%b want 1 0", queue_full, issue_queue_rdy);
    else passed++;
    tick();  // dropped: full with no pop
    mem_stall = 0;
    disp(1'b0, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0, 1'b0, 32'h0, 6'd24);
    settle();
    total++;
    if (issue_queue_rdy !== 1'b1 || i_rd_tag !== 6'd20)
      $display("FAIL full_pushpop got rdy=%b rd=%0d want 1 20", issue_queue_rdy, i_rd_tag);
    else passed++;
    tick();
    clear_inputs();
    for (int k = 0; k < DEPTH; k++) begin
      settle();
      total++;
      if (issue_queue_rdy !== 1'b1 || i_rd_tag !== 6'(21 + k) ||
          queue_full !== (k == 0 ? 1'b1 : 1'b0))
        $display("FAIL drain_%0d got rdy=%b rd=%0d full=%b want 1 %0d %b", k,
                 issue_queue_rdy, i_rd_tag, queue_full, 21 + k, k == 0);
      else passed++;
      tick();
    end
    settle();
    total++;
    if (issue_queue_rdy !== 1'b0 || queue_full !== 1'b0)
      $display("FAIL drained got rdy=%b full=%b want 0 0", issue_queue_rdy, queue_full);
    else passed++;
    tick();
  endtask

  task automatic test_stall();
    mem_stall = 1;
    disp(1'b0, 6'd0, 32'h700, 1'b1, 6'd0, 32'h0, 1'b0, 32'h0, 6'd7);
    tick();
    dispatch_en = 0;
    for (int k = 0; k < 2; k++) begin
      settle();
      total++;
      if (issue_queue_rdy !== 1'b0 || i_rd_tag !== 6'd7)
        $display("FAIL stall_hold_%0d got rdy=%b rd=%0d want 0 7", k, issue_queue_rdy, i_rd_tag);
      else passed++;
      tick();
    end
    mem_stall = 0;
    settle();
    total++;
    if (issue_queue_rdy !== 1'b1 || i_rs1_data !== 32'h700)
      $display("FAIL stall_release got rdy=%b rs1=%h want 1 700", issue_queue_rdy, i_rs1_data);
    else passed++;
    tick();
    clear_inputs();
  endtask

`ifdef LDST_CDB_BYPASS_EN
  task automatic test_bypass();
    disp(1'b0, 6'd7, 32'h0, 1'b0, 6'd0, 32'h0, 1'b0, 32'h0, 6'd13);
    cdb_valid = 1; cdb_tag = 6'd7; cdb_result = 32'h77;
    tick();
    clear_inputs();
    settle();
    total++;
    if (issue_queue_rdy !== 1'b1 || i_rs1_data !== 32'h77)
      $display("FAIL bypass got rdy=%b rs1=%h want 1 77", issue_queue_rdy, i_rs1_data);
    else passed++;
    tick();
  endtask
`endif

  task automatic test_random();
    ent_t h;
    logic exp_rdy;
    rst = 1;
    tick();
    rst = 0;
    for (int c = 0; c < 2000; c++) begin
      dispatch_en    = ($urandom_range(0, 1) == 1);
      d_ld_st_opcode = 1'($urandom);
      d_rs1_tag      = 6'($urandom_range(0, 7));
      d_rs1_data     = $urandom;
      d_rs1_valid    = ($urandom_range(0, 1) == 1);
      d_rs2_tag      = 6'($urandom_range(0, 7));
      d_rs2_data     = $urandom;
      d_rs2_valid    = ($urandom_range(0, 1) == 1);
      d_immediate    = $urandom;
      d_rd_tag       = 6'($urandom);
      cdb_valid      = ($urandom_range(0, 9) < 4);
      cdb_tag        = 6'($urandom_range(0, 7));
      cdb_result     = $urandom;
      mem_stall      = ($urandom_range(0, 4) == 0);
      settle();
      exp_rdy = model_rdy();
      if (mq.size() > 0) h = mq[0];
      else begin
        h.op = 0; h.d1 = 0; h.d2 = 0; h.imm = 0; h.rd = 0;
      end
      total++;
      if (queue_full !== (mq.size() == DEPTH))
        $display("FAIL rand_full c=%0d got %b want %b", c, queue_full, mq.size() == DEPTH);
      else passed++;
      total++;
      if (issue_queue_rdy !== exp_rdy)
        $display("FAIL rand_rdy c=%0d got %b want %b", c, issue_queue_rdy, exp_rdy);
      else passed++;
      total++;
      if (i_ld_st_opcode !== h.op || i_rd_tag !== h.rd || i_immediate !== h.imm)
        $display("FAIL rand_head c=%0d got op=%b rd=%0d imm=%h want %b %0d %h", c,
                 i_ld_st_opcode, i_rd_tag, i_immediate, h.op, h.rd, h.imm);
      else passed++;
      total++;
      if (i_rs1_data !== h.d1 || i_rs2_data !== h.d2)
        $display("FAIL rand_data c=%0d got rs1=%h rs2=%h want %h %h", c,
                 i_rs1_data, i_rs2_data, h.d1, h.d2);
      else passed++;
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    #1;
    total++;
    if (queue_full !== 1'b0 || issue_queue_rdy !== 1'b0 || i_rd_tag !== '0)
      $display("FAIL initial_reset got full=%b rdy=%b rd=%0d want 0 0 0",
               queue_full, issue_queue_rdy, i_rd_tag);
    else passed++;
    tick();
    tick();
    rst = 0;
    test_reset();
    test_ready_load();
    test_wakeup();
    test_ordering();
    test_full_wrap();
    test_stall();
`ifdef LDST_CDB_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
